// File: rtl/beam_sweep_sequencer.sv
// Phased-array sweep sequencer: per angle, load speaker phases, settle, burst, then listen.
// Optional SWEEP_PINGPONG_EN: angle index bounces 0..N-1..0 instead of wrapping.
module beam_sweep_sequencer #(
    parameter int unsigned N_SPK      = 37,
    parameter int unsigned N_ANGLES   = 16,
    parameter logic [6:0]  ADDR_BASE  = 7'h11,
    parameter int unsigned SETTLE_CYC = 8,
    localparam int unsigned TA_W      = $clog2(N_ANGLES * N_SPK),
    localparam int unsigned AI_W      = $clog2(N_ANGLES)
) (
    input  logic            clk,
    input  logic            res,
    input  logic            start,
    input  logic            stop,
    input  logic [15:0]     burst_len,
    input  logic [15:0]     listen_len,
    output logic [TA_W-1:0] tbl_addr,
    input  logic [3:0]      tbl_data,
    output logic            reg_we,
    output logic [6:0]      reg_addr,
    output logic [3:0]      reg_wdata,
    output logic            spk_on,
    output logic            mic_on,
    output logic            busy,
    output logic [AI_W-1:0] angle_idx,
    output logic            frame_done,
    output logic            sweep_done
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StBurst,
        StListen,
        StDone
    } state_e;

    localparam logic [AI_W-1:0] LastAngle = AI_W'(N_ANGLES - 1);
    localparam logic [15:0]     LoadLast  = 16'(N_SPK);
    localparam logic [15:0]     SettleEnd = 16'(SETTLE_CYC - 1);

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     len_q, len_d;
    logic [AI_W-1:0] angle_q, angle_d;
    logic            stop_req_q, stop_req_d;
`ifdef SWEEP_PINGPONG_EN
    logic            dir_q, dir_d;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            len_q      <= 16'd0;
            angle_q    <= '0;
            stop_req_q <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            angle_q    <= angle_d;
            stop_req_q <= stop_req_d;
`ifdef SWEEP_PINGPONG_EN
            dir_q      <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        len_d      = len_q;
        angle_d    = angle_q;
        stop_req_d = stop_req_q | stop;
`ifdef SWEEP_PINGPONG_EN
        dir_d      = dir_q;
`endif
        tbl_addr   = '0;
        reg_we     = 1'b0;
        reg_addr   = 7'd0;
        reg_wdata  = 4'd0;
        spk_on     = 1'b0;
        mic_on     = 1'b0;
        frame_done = 1'b0;
        sweep_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                // stop in IDLE is discarded; with start in the same cycle it also blocks the start
                stop_req_d = 1'b0;
                cnt_d      = 16'd0;
                if (start && !stop) begin
                    state_d = StLoad;
                    angle_d = '0;
`ifdef SWEEP_PINGPONG_EN
                    dir_d   = 1'b0;
`endif
                end
            end
            StLoad: begin
                // Table read runs one cycle ahead of the matching register write
                if (cnt_q < LoadLast) begin
                    tbl_addr = TA_W'(angle_q) * TA_W'(N_SPK) + TA_W'(cnt_q);
                end
                if (cnt_q != 16'd0) begin
                    reg_we    = 1'b1;
                    reg_addr  = ADDR_BASE + 7'(cnt_q) - 7'd1;
                    reg_wdata = tbl_data;
                end
                if (cnt_q == LoadLast) begin
                    state_d = StSettle;
                    cnt_d   = 16'd0;
                end
            end
            StSettle: begin
                if (cnt_q == SettleEnd) begin
                    cnt_d = 16'd0;
                    if (burst_len != 16'd0) begin
                        state_d = StBurst;
                        len_d   = burst_len;
                    end else if (listen_len != 16'd0) begin
                        state_d = StListen;
                        len_d   = listen_len;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StBurst: begin
                spk_on = 1'b1;
                if (cnt_q == len_q - 16'd1) begin
                    cnt_d = 16'd0;
                    if (listen_len != 16'd0) begin
                        state_d = StListen;
                        len_d   = listen_len;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StListen: begin
                mic_on = 1'b1;
                if (cnt_q == len_q - 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = StDone;
                end
            end
            StDone: begin
                frame_done = 1'b1;
                cnt_d      = 16'd0;
`ifdef SWEEP_PINGPONG_EN
                // Turn-around skips the end angle so it is not visited twice in a row
                if (!dir_q) begin
                    if (angle_q == LastAngle) begin
                        sweep_done = 1'b1;
                        dir_d      = 1'b1;
                        angle_d    = LastAngle - AI_W'(1);
                    end else begin
                        angle_d = angle_q + AI_W'(1);
                    end
                end else begin
                    if (angle_q == '0) begin
                        sweep_done = 1'b1;
                        dir_d      = 1'b0;
                        angle_d    = AI_W'(1);
                    end else begin
                        angle_d = angle_q - AI_W'(1);
                    end
                end
`else
                if (angle_q == LastAngle) begin
                    sweep_done = 1'b1;
                    angle_d    = '0;
                end else begin
                    angle_d = angle_q + AI_W'(1);
                end
`endif
                state_d = (stop_req_q || stop) ? StIdle : StLoad;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign angle_idx = angle_q;

endmodule

// File: tb/tb_beam_sweep_sequencer.sv
// Directed bench for beam_sweep_sequencer with a registered phase-table model.
module tb_beam_sweep_sequencer;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] burst_len = 16'd0;
    logic [15:0] listen_len = 16'd0;
    logic [9:0]  tbl_addr;
    logic [3:0]  tbl_data = 4'd0;
    logic        reg_we;
    logic [6:0]  reg_addr;
    logic [3:0]  reg_wdata;
    logic        spk_on;
    logic        mic_on;
    logic        busy;
    logic [3:0]  angle_idx;
    logic        frame_done;
    logic        sweep_done;

    int vectors = 0;
    int miscompares = 0;
    int overlap = 0;

    beam_sweep_sequencer dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .listen_len (listen_len),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .spk_on     (spk_on),
        .mic_on     (mic_on),
        .busy       (busy),
        .angle_idx  (angle_idx),
        .frame_done (frame_done),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] tv(input int i);
        return 4'((i * 7 + 3) % 16);
    endfunction

    // Synchronous table: data for an address appears one cycle later
    always @(posedge clk) tbl_data <= tv(int'(tbl_addr));

    always @(posedge clk) if (spk_on && mic_on) overlap++;

`ifdef SWEEP_PINGPONG_EN
    function automatic int exp_angle(input int j);
        int m;
        m = j % 30;
        return (m < 16) ? m : 30 - m;
    endfunction
    function automatic logic exp_sweep(input int j);
        return (j == 15) || (j == 30);
    endfunction
    localparam int AfterSweepAngle = 14;
    localparam int AfterStopAngle  = 2;
`else
    function automatic int exp_angle(input int j);
        return j % 16;
    endfunction
    function automatic logic exp_sweep(input int j);
        return (j % 16) == 15;
    endfunction
    localparam int AfterSweepAngle = 0;
    localparam int AfterStopAngle  = 4;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_we"}, 32'(reg_we), 0);
        check({tag, "_addr"}, 32'(reg_addr), 0);
        check({tag, "_wdata"}, 32'(reg_wdata), 0);
        check({tag, "_spk"}, 32'(spk_on), 0);
        check({tag, "_mic"}, 32'(mic_on), 0);
        check({tag, "_tbl"}, 32'(tbl_addr), 0);
        check({tag, "_angle"}, 32'(angle_idx), 0);
        check({tag, "_frame"}, 32'(frame_done), 0);
        check({tag, "_sweep"}, 32'(sweep_done), 0);
    endtask

    initial begin
        int n;
        int nf;
        int spk_cnt;
        int mic_cnt;
        logic saw_act;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        res = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // Load of angle 0
        burst_len  = 16'd100;
        listen_len = 16'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load0_busy", 32'(busy), 1);
        check("load0_tbl", 32'(tbl_addr), 0);
        check("load0_we", 32'(reg_we), 0);
        for (int c = 1; c <= 37; c++) begin
            tick();
            check("load_we", 32'(reg_we), 1);
            check("load_addr", 32'(reg_addr), 32'(7'h11 + c - 1));
            check("load_wdata", 32'(reg_wdata), 32'(tv(c - 1)));
            if (c < 37) check("load_tbl", 32'(tbl_addr), 32'(c));
        end
        n = 0;
        do begin
            tick();
            n++;
            if (!spk_on && reg_we) check("settle_we", 32'(reg_we), 0);
        end while (!spk_on && n < 40);
        check("settle_to_burst", 32'(n), 9);

        // Burst/listen lengths; mid-state changes must not take effect this angle
        n = 0;
        while (spk_on && n < 1000) begin
            n++;
            if (n == 10) burst_len = 16'd5;
            tick();
        end
        check("burst_len", 32'(n), 100);
        check("listen_start", 32'(mic_on), 1);
        n = 0;
        while (mic_on && n < 1000) begin
            n++;
            if (n == 10) listen_len = 16'd4;
            tick();
        end
        check("listen_len", 32'(n), 200);
        check("frame0_done", 32'(frame_done), 1);
        check("frame0_sweep", 32'(sweep_done), 0);
        check("frame0_angle", 32'(angle_idx), 0);
        tick();
        check("frame_pulse", 32'(frame_done), 0);
        check("angle1", 32'(angle_idx), 1);
        check("angle1_tbl", 32'(tbl_addr), 37);
        tick();
        check("angle1_addr", 32'(reg_addr), 32'(7'h11));
        check("angle1_wdata", 32'(reg_wdata), 32'(tv(37)));

        // Full sweep to the end of angle 15
        nf = 1;
        n = 0;
        while (!sweep_done && n < 20000) begin
            tick();
            n++;
            if (frame_done) nf++;
        end
        check("sweep_seen", 32'(sweep_done), 1);
        check("sweep_frames", 32'(nf), 16);
        check("sweep_angle", 32'(angle_idx), 15);
        tick();
        check("post_sweep_angle", 32'(angle_idx), 32'(AfterSweepAngle));
        for (int c = 0; c < 37; c++) begin
            if (c > 0) tick();
            check("post_sweep_tbl", 32'(tbl_addr), 32'(AfterSweepAngle * 37 + c));
        end

        // Stop during angle 3 burst
        n = 0;
        while (!(spk_on && angle_idx == 4'd3) && n < 10000) begin
            tick();
            n++;
        end
        check("angle3_burst", 32'(spk_on), 1);
        spk_cnt = 0;
        mic_cnt = 0;
        n = 0;
        while (!frame_done && n < 1000) begin
            if (spk_on) spk_cnt++;
            if (mic_on) mic_cnt++;
            stop = (n == 2);
            tick();
            n++;
        end
        stop = 1'b0;
        check("stop_spk_cnt", 32'(spk_cnt), 5);
        check("stop_mic_cnt", 32'(mic_cnt), 4);
        check("stop_done_busy", 32'(busy), 1);
        tick();
        check("stop_idle", 32'(busy), 0);
        check("stop_angle", 32'(angle_idx), 32'(AfterStopAngle));
        tick();
        tick();
        check("stop_stays_idle", 32'(busy), 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", 32'(busy), 0);

        // Zero-length burst and listen
        burst_len  = 16'd0;
        listen_len = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_angle0", 32'(angle_idx), 0);
        saw_act = 1'b0;
        n = 0;
        while (!frame_done && n < 500) begin
            if (spk_on || mic_on) saw_act = 1'b1;
            stop = (n == 5);
            tick();
            n++;
        end
        stop = 1'b0;
        check("zero_done_at", 32'(n), 46);
        check("zero_no_act", 32'(saw_act), 0);
        tick();
        check("zero_idle", 32'(busy), 0);
        check("zero_angle1", 32'(angle_idx), 1);

        // Reset during load at k=10, with a pending stop that reset must clear
        burst_len  = 16'd3;
        listen_len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            stop = (i == 5);
            tick();
        end
        stop = 1'b0;
        check("mid_tbl", 32'(tbl_addr), 10);
        check("mid_addr", 32'(reg_addr), 32'(7'h11 + 9));
        res = 1'b1;
        tick();
        check_idle_outputs("midreset");
        res = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reload_tbl", 32'(tbl_addr), 0);
        tick();
        check("reload_addr", 32'(reg_addr), 32'(7'h11));
        check("reload_wdata", 32'(reg_wdata), 32'(tv(0)));
        for (int j = 0; j <= 30; j++) begin
            n = 0;
            while (!frame_done && n < 500) begin
                tick();
                n++;
            end
            check("seq_frame", 32'(frame_done), 1);
            check("seq_angle", 32'(angle_idx), 32'(exp_angle(j)));
            check("seq_sweep", 32'(sweep_done), 32'(exp_sweep(j)));
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n = 0;
        while (!frame_done && n < 500) begin
            tick();
            n++;
        end
        tick();
        check("final_idle", 32'(busy), 0);
        check("no_overlap", 32'(overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
